// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: function codes, FSM states, default width.
package alu_pkg;
    localparam int WIDTH = 32;

    localparam logic [2:0] F_AND  = 3'b000;
    localparam logic [2:0] F_OR   = 3'b001;
    localparam logic [2:0] F_ADD  = 3'b010;
    localparam logic [2:0] F_ILL  = 3'b011;
    localparam logic [2:0] F_ANDN = 3'b100;
    localparam logic [2:0] F_ORN  = 3'b101;
    localparam logic [2:0] F_SUB  = 3'b110;
    localparam logic [2:0] F_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin arbiter, combinational; last=1 means client 1 won most recently.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);
    assign grant[0] = req[0] & (~req[1] | last);
    assign grant[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/alu_sched.sv
// Shares one external combinational ALU between two requesters, round-robin.
// Legal op: accept -> EXEC (ALU operands registered) -> RESP; illegal f skips EXEC.
module alu_sched #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [2:0]       req_f0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_f1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    input  logic             alu_of,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             rsp_of,
    output logic             rsp_err,
    output logic [15:0]      ops_done
);
    import alu_pkg::*;

    state_t           r_state;
    state_t           w_next;
    logic             r_last;
    logic [1:0]       w_grant;
    logic             w_acc;
    logic             w_sel;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [2:0]       w_f;
    logic             w_ill;
    logic             w_rsp_hs;

    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_f;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_y;
    logic             r_rsp_zero;
    logic             r_rsp_of;
    logic             r_rsp_err;
    logic [15:0]      r_ops_done;

    rr_arb2 u_arb (
        .req   (req_valid),
        .last  (r_last),
        .grant (w_grant)
    );

    assign req_ready = (r_state == IDLE) ? w_grant : 2'b00;
    assign w_acc     = |req_ready;
    assign w_sel     = req_ready[1];
    assign w_a       = w_sel ? req_a1 : req_a0;
    assign w_b       = w_sel ? req_b1 : req_b0;
    assign w_f       = w_sel ? req_f1 : req_f0;
    assign w_ill     = (w_f == F_ILL);
    assign rsp_valid = (r_state == RESP);
    assign w_rsp_hs  = rsp_valid & rsp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = w_ill ? RESP : EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last     <= 1'b1;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_f    <= F_AND;
            r_rsp_id   <= 1'b0;
            r_rsp_y    <= '0;
            r_rsp_zero <= 1'b0;
            r_rsp_of   <= 1'b0;
            r_rsp_err  <= 1'b0;
            r_ops_done <= '0;
        end else begin
            if (w_acc) begin
                r_last   <= w_sel;
                r_rsp_id <= w_sel;
                // Illegal ops never reach the ALU, so its operand regs keep the previous op.
                if (w_ill) begin
                    r_rsp_y    <= '0;
                    r_rsp_zero <= 1'b0;
                    r_rsp_of   <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end else begin
                    r_alu_a <= w_a;
                    r_alu_b <= w_b;
                    r_alu_f <= w_f;
                end
            end
            if (r_state == EXEC) begin
                r_rsp_y    <= alu_y;
                r_rsp_zero <= alu_zero;
                r_rsp_of   <= alu_of;
                r_rsp_err  <= 1'b0;
            end
            if (w_rsp_hs && (r_ops_done != 16'hFFFF)) begin
                r_ops_done <= r_ops_done + 16'd1;
            end
        end
    end

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_f    = r_alu_f;
    assign rsp_id   = r_rsp_id;
    assign rsp_y    = r_rsp_y;
    assign rsp_zero = r_rsp_zero;
    assign rsp_of   = r_rsp_of;
    assign rsp_err  = r_rsp_err;
    assign ops_done = r_ops_done;
endmodule
